// File: rtl/ifmap_pop_ctrl_pkg.sv
// ifmap_pop_ctrl_pkg -- shared lane state encoding and default sizes for the ifmap pop controller.
// Revision 1.0
`default_nettype none

package ifmap_pop_ctrl_pkg;

  localparam int NUM_IFMAP_FIFO_DEF = 32;
  localparam int POP_CNT_W_DEF      = 32;

  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_POP  = 2'd1,
    LANE_DONE = 2'd2
  } lane_state_t;

endpackage

`default_nettype wire

// File: rtl/ifmap_pop_lane.sv
// ifmap_pop_lane -- single-lane IDLE/POP/DONE sequencer with a pop-remaining counter.
// Revision 1.0
`default_nettype none

module ifmap_pop_lane
  import ifmap_pop_ctrl_pkg::*;
#(
  parameter int POP_CNT_W = POP_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 need_pop,
  input  logic [POP_CNT_W-1:0] pop_num,
  input  logic                 fifo_empty,
  input  logic                 pe_ready,
  output logic                 pop,
  output logic                 done,
  output logic                 in_pop,
  output logic                 proto_err
);

  localparam logic [POP_CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [POP_CNT_W-1:0] CNT_ONE  = {{(POP_CNT_W-1){1'b0}}, 1'b1};

  lane_state_t          state;
  logic [POP_CNT_W-1:0] remaining;

  assign in_pop    = (state == LANE_POP);
  // clear suppresses the strobe in its own cycle so an abort never moves data
  assign pop       = in_pop && !fifo_empty && pe_ready && !clear;
  assign proto_err = in_pop && need_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LANE_IDLE;
      remaining <= CNT_ZERO;
      done      <= 1'b0;
    end else if (clear) begin
      state     <= LANE_IDLE;
      remaining <= CNT_ZERO;
      done      <= 1'b0;
    end else begin
      case (state)
        LANE_IDLE, LANE_DONE: begin
          if (need_pop) begin
            remaining <= pop_num;
            if (pop_num != CNT_ZERO) begin
              state <= LANE_POP;
              done  <= 1'b0;
            end else begin
              state <= LANE_DONE;
              done  <= 1'b1;
            end
          end
        end
        LANE_POP: begin
          if (pop) begin
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
              state <= LANE_DONE;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state     <= LANE_IDLE;
          remaining <= CNT_ZERO;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifmap_pop_ctrl.sv
// ifmap_pop_ctrl -- per-lane ifmap FIFO pop control with busy/sticky-error aggregation (rev 1.0).
// Optional stall-cycle counter enabled by defining IFMAP_POP_STALL_CNT_EN.
`default_nettype none

module ifmap_pop_ctrl
  import ifmap_pop_ctrl_pkg::*;
#(
  parameter int NUM_IFMAP_FIFO = NUM_IFMAP_FIFO_DEF,
  parameter int POP_CNT_W      = POP_CNT_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear_i,
  input  logic [NUM_IFMAP_FIFO-1:0]           need_pop_i,
  input  logic [NUM_IFMAP_FIFO*POP_CNT_W-1:0] pop_num_i,
  input  logic [NUM_IFMAP_FIFO-1:0]           fifo_empty_i,
  input  logic [NUM_IFMAP_FIFO-1:0]           pe_ready_i,
  output logic [NUM_IFMAP_FIFO-1:0]           fifo_pop_o,
  output logic [NUM_IFMAP_FIFO-1:0]           done_matrix_o,
  output logic                                busy_o,
  output logic                                err_o,
  output logic [31:0]                         stall_cnt_o
);

  logic [NUM_IFMAP_FIFO-1:0] lane_in_pop;
  logic [NUM_IFMAP_FIFO-1:0] lane_proto_err;

  generate
    for (genvar k = 0; k < NUM_IFMAP_FIFO; k++) begin : g_lane
      ifmap_pop_lane #(
        .POP_CNT_W (POP_CNT_W)
      ) u_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear_i),
        .need_pop   (need_pop_i[k]),
        .pop_num    (pop_num_i[k*POP_CNT_W +: POP_CNT_W]),
        .fifo_empty (fifo_empty_i[k]),
        .pe_ready   (pe_ready_i[k]),
        .pop        (fifo_pop_o[k]),
        .done       (done_matrix_o[k]),
        .in_pop     (lane_in_pop[k]),
        .proto_err  (lane_proto_err[k])
      );
    end
  endgenerate

  assign busy_o = |lane_in_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (clear_i) begin
      err_o <= 1'b0;
    end else if (|lane_proto_err) begin
      err_o <= 1'b1;
    end
  end

`ifdef IFMAP_POP_STALL_CNT_EN
  logic        stall_any;
  logic [31:0] stall_cnt;

  // a stall is any popping lane that could not move data this cycle
  assign stall_any = |(lane_in_pop & ~fifo_pop_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (clear_i) begin
      stall_cnt <= 32'd0;
    end else if (stall_any && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifmap_pop_ctrl.sv
// tb_ifmap_pop_ctrl -- directed scenarios plus randomized traffic against a per-lane pop/done reference model.
`default_nettype none

module tb_ifmap_pop_ctrl;

  localparam int N = 32;
  localparam int W = 32;
`ifdef IFMAP_POP_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear_i = 1'b0;
  logic [N-1:0]   need_pop_i = '0;
  logic [N-1:0]   fifo_empty_i = '0;
  logic [N-1:0]   pe_ready_i = '0;
  logic [W-1:0]   pn [N];
  logic [N*W-1:0] pop_num_i;
  logic [N-1:0]   fifo_pop_o;
  logic [N-1:0]   done_matrix_o;
  logic           busy_o;
  logic           err_o;
  logic [31:0]    stall_cnt_o;

  always_comb begin
    for (int k = 0; k < N; k++) pop_num_i[k*W +: W] = pn[k];
  end

  ifmap_pop_ctrl #(
    .NUM_IFMAP_FIFO (N),
    .POP_CNT_W      (W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear_i),
    .need_pop_i    (need_pop_i),
    .pop_num_i     (pop_num_i),
    .fifo_empty_i  (fifo_empty_i),
    .pe_ready_i    (pe_ready_i),
    .fifo_pop_o    (fifo_pop_o),
    .done_matrix_o (done_matrix_o),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = idle, 1 = popping, 2 = done
  int          m_st [N];
  logic [W-1:0] m_rem [N];
  logic        m_err;
  logic [31:0] m_stall;
  int          checks = 0;
  int          errors = 0;
  int          pops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_st[k]  = 0;
      m_rem[k] = '0;
    end
    m_err   = 1'b0;
    m_stall = 32'd0;
  endfunction

  // Called at a falling edge with inputs already driven; checks then advances one cycle.
  task automatic step();
    logic [N-1:0] ep, eb, ed;
    #1;
    for (int k = 0; k < N; k++) begin
      eb[k] = (m_st[k] == 1);
      ed[k] = (m_st[k] == 2);
      ep[k] = eb[k] && !fifo_empty_i[k] && pe_ready_i[k] && !clear_i && rst_n;
    end
    chk("fifo_pop", 64'(fifo_pop_o), 64'(ep));
    chk("busy", 64'(busy_o), 64'(|eb));
    chk("done_matrix", 64'(done_matrix_o), 64'(ed));
    chk("err", 64'(err_o), 64'(m_err));
    chk("stall_cnt", 64'(stall_cnt_o), STALL_EN ? 64'(m_stall) : 64'd0);
    if (!rst_n || clear_i) begin
      model_reset();
    end else begin
      if (((eb & ~ep) != '0) && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
      for (int k = 0; k < N; k++) begin
        if (m_st[k] == 1) begin
          if (need_pop_i[k]) m_err = 1'b1;
          if (ep[k]) begin
            m_rem[k] = m_rem[k] - 1;
            if (m_rem[k] == 0) m_st[k] = 2;
          end
        end else if (need_pop_i[k]) begin
          m_rem[k] = pn[k];
          m_st[k]  = (pn[k] != 0) ? 1 : 2;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < N; k++) pn[k] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    step();
    chk("reset_done", 64'(done_matrix_o), 64'd0);
    rst_n = 1'b1;
    pe_ready_i = '1;

    // Pointwise: every lane pops once
    for (int k = 0; k < N; k++) pn[k] = 32'd1;
    need_pop_i = '1;
    step();
    need_pop_i = '0;
    #1 chk("pointwise_pop_T1", 64'(fifo_pop_o), 64'(32'hFFFF_FFFF));
    step();
    chk("pointwise_done_T2", 64'(done_matrix_o), 64'(32'hFFFF_FFFF));
    clear_i = 1'b1; step(); clear_i = 1'b0;

    // Depthwise
    for (int k = 0; k < N; k++) pn[k] = '0;
    pn[0] = 32'd3;
    pn[29] = 32'd30;
    need_pop_i = 32'hE000_0001;
    step();
    need_pop_i = '0;
    for (int c = 1; c <= 31; c++) begin
      if (c == 1)  chk("depth_lanes30_31_T1", 64'(done_matrix_o[31:30]), 64'd3);
      if (c == 3)  chk("depth_lane0_T3", 64'(done_matrix_o[0]), 64'd0);
      if (c == 4)  chk("depth_lane0_T4", 64'(done_matrix_o[0]), 64'd1);
      if (c == 30) chk("depth_lane29_T30", 64'(done_matrix_o[29]), 64'd0);
      if (c == 31) chk("depth_lane29_T31", 64'(done_matrix_o[29]), 64'd1);
      step();
    end
    clear_i = 1'b1; step(); clear_i = 1'b0;

    // Backpressure on lane 5
    pn[5] = 32'd4;
    need_pop_i = 32'h0000_0020;
    step();
    need_pop_i = '0;
    pops = 0;
    for (int c = 1; c <= 9; c++) begin
      fifo_empty_i[5] = (c % 2 == 0);
      #1 pops += int'(fifo_pop_o[5]);
      if (c == 7) chk("bp_not_done_T7", 64'(done_matrix_o[5]), 64'd0);
      if (c == 8) chk("bp_done_T8", 64'(done_matrix_o[5]), 64'd1);
      step();
    end
    chk("bp_pop_total", 64'(pops), 64'd4);
    chk("bp_stall_total", 64'(stall_cnt_o), STALL_EN ? 64'd3 : 64'd0);
    fifo_empty_i = '0;
    clear_i = 1'b1; step(); clear_i = 1'b0;

    // Protocol error: re-pulse lane 2 mid-POP
    pn[2] = 32'd5;
    need_pop_i = 32'h0000_0004;
    step();
    need_pop_i = '0;
    step();
    step();
    pn[2] = 32'd9;
    need_pop_i = 32'h0000_0004;
    step();
    need_pop_i = '0;
    chk("proto_err_set", 64'(err_o), 64'd1);
    step();
    step();
    chk("proto_done_orig_count", 64'(done_matrix_o[2]), 64'd1);
    chk("proto_err_sticky", 64'(err_o), 64'd1);
    clear_i = 1'b1; step(); clear_i = 1'b0;
    chk("proto_err_cleared", 64'(err_o), 64'd0);

    // Maximum pop count is accepted as a long burst
    pn[7] = '1;
    need_pop_i = 32'h0000_0080;
    step();
    need_pop_i = '0;
    repeat (3) step();
    chk("maxcnt_busy", 64'(busy_o), 64'd1);
    chk("maxcnt_not_done", 64'(done_matrix_o[7]), 64'd0);
    clear_i = 1'b1; step(); clear_i = 1'b0;

    // Asynchronous reset mid-POP
    for (int k = 0; k < N; k++) pn[k] = 32'd10;
    need_pop_i = '1;
    step();
    need_pop_i = '0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rst_pop", 64'(fifo_pop_o), 64'd0);
    chk("abort_rst_done", 64'(done_matrix_o), 64'd0);
    chk("abort_rst_busy", 64'(busy_o), 64'd0);
    chk("abort_rst_err", 64'(err_o), 64'd0);
    chk("abort_rst_stall", 64'(stall_cnt_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // clear wins over a simultaneous start
    for (int k = 0; k < N; k++) pn[k] = 32'd3;
    need_pop_i = '1;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    need_pop_i = '0;
    chk("clear_wins_busy", 64'(busy_o), 64'd0);
    chk("clear_wins_done", 64'(done_matrix_o), 64'd0);

    // Randomized traffic
    repeat (400) begin
      for (int k = 0; k < N; k++) begin
        need_pop_i[k]   = ($urandom_range(0, 11) == 0);
        pn[k]           = W'($urandom_range(0, 6));
        fifo_empty_i[k] = ($urandom_range(0, 3) == 0);
        pe_ready_i[k]   = ($urandom_range(0, 4) != 0);
      end
      clear_i = ($urandom_range(0, 79) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifmap_pop_ctrl.md
IFMAP_POP_CTRL -- requirements
Module: ifmap_pop_ctrl

Interface
REQ-001 SHALL have parameter NUM_IFMAP_FIFO, default 32, number of ifmap FIFO lanes.
REQ-002 SHALL have parameter POP_CNT_W, default 32, width of per-lane pop count.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous abort; all lanes to IDLE.
REQ-006 SHALL have port need_pop_i  input  NUM_IFMAP_FIFO  per-lane start pulse, sampled each cycle.
REQ-007 SHALL have port pop_num_i  input  NUM_IFMAP_FIFO x POP_CNT_W  per-lane pop count, valid when need_pop_i bit is high.
REQ-008 SHALL have port fifo_empty_i  input  NUM_IFMAP_FIFO  per-lane ifmap FIFO empty.
REQ-009 SHALL have port pe_ready_i  input  NUM_IFMAP_FIFO  per-lane PE row accepts data this cycle.
REQ-010 SHALL have port fifo_pop_o  output  NUM_IFMAP_FIFO  per-lane pop strobe to FIFO and PE-row valid.
REQ-011 SHALL have port done_matrix_o  output  NUM_IFMAP_FIFO  per-lane pop-complete flag, feeds preheat controller.
REQ-012 SHALL have port busy_o  output  1  OR of all lanes in POP.
REQ-013 SHALL have port err_o  output  1  sticky protocol error.
REQ-014 SHALL have port stall_cnt_o  output  32  stall-cycle count (see Configuration).

Function
REQ-015 Each lane SHALL run an independent FSM: IDLE, POP, DONE.
REQ-016 IDLE/DONE + need_pop_i bit high: latch pop_num_i into lane remaining counter; next state POP if value nonzero, else DONE.
REQ-017 fifo_pop_o[k] SHALL be combinational: lane k in POP and !fifo_empty_i[k] and pe_ready_i[k]; never asserted outside POP.
REQ-018 Each pop SHALL decrement remaining by 1; pop with remaining==1 moves lane to DONE next cycle; no wrap, count never below 0.
REQ-019 Latency: need_pop at cycle T -> first pop possible at T+1; done_matrix_o[k] high the cycle after the last pop (pop_num 0: high at T+1).
REQ-020 done_matrix_o[k] SHALL be registered, high exactly in DONE, held until next need_pop_i[k] or clear_i.
REQ-021 need_pop_i[k] while lane k in POP SHALL be ignored (count unchanged) and SHALL set err_o.
REQ-022 clear_i SHALL have priority over need_pop_i and pops: next cycle all lanes IDLE, done_matrix_o=0, err_o=0, fifo_pop_o=0 in the clear cycle.
REQ-023 busy_o SHALL be combinational OR of lanes in POP.
REQ-024 pop_num_i = 2^POP_CNT_W-1 SHALL be supported exactly.

Reset
REQ-025 rst_n low SHALL force all lanes IDLE, counters 0, done_matrix_o=0, err_o=0, stall_cnt_o=0, immediately and asynchronously, including mid-POP; fifo_pop_o=0 while reset asserted.

Configuration
REQ-026 Macro IFMAP_POP_STALL_CNT_EN defined: stall_cnt_o increments (saturating at 0xFFFF_FFFF) each cycle any lane is in POP with fifo_pop_o bit low; cleared by clear_i or reset.
REQ-027 Macro undefined: stall_cnt_o SHALL be constant 0 and no counter logic synthesized.

Structure
REQ-028 Shared package SHALL hold the lane state enum (IDLE, POP, DONE), NUM_IFMAP_FIFO and POP_CNT_W defaults.
REQ-029 One sub-module ifmap_pop_lane (single-lane FSM + counter) SHALL be instantiated NUM_IFMAP_FIFO times by generate; top holds busy/err/stall logic.

Verification
REQ-030 Pointwise: need_pop_i=0xFFFF_FFFF, all pop_num=1, FIFOs non-empty, ready=1 -> one pop per lane at T+1, done_matrix_o=0xFFFF_FFFF at T+2.
REQ-031 Depthwise: lane 0 pop_num=3, lane 29 pop_num=30, lanes 30-31 pop_num=0 -> lanes 30-31 done at T+1, lane 0 done at T+4, lane 29 done at T+31.
REQ-032 Backpressure: lane 5 pop_num=4, fifo_empty toggles every other cycle -> exactly 4 pops, done after 4th; with macro, stall_cnt_o=3.
REQ-033 Protocol: need_pop_i[2] re-pulsed mid-POP with pop_num=9 -> original count completes, err_o=1 sticky until clear_i.
REQ-034 Abort: rst_n low mid-POP -> fifo_pop_o=0 immediately, all outputs 0; clear_i with simultaneous need_pop -> lanes IDLE next cycle.
